// File: rtl/stopwatch_bcd_counter.sv
// SS.cc stopwatch that feeds a 4-digit BCD value to the 7-segment display driver.
// Build option: define LAP_HOLD_EN to add btn_lap and the lap/hold display freeze.

module sw_btn_path #(
    parameter int DEBOUNCE_CYC = 1_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic press
);
    localparam int CW = $clog2(DEBOUNCE_CYC + 1);

    logic [1:0]    sync;
    logic          level;
    logic [CW-1:0] cnt;

    // A new level is accepted only after the synced input has disagreed with
    // the current level for DEBOUNCE_CYC consecutive cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync  <= '0;
            level <= 1'b0;
            cnt   <= '0;
            press <= 1'b0;
        end else begin
            sync  <= {sync[0], btn};
            press <= 1'b0;
            if (sync[1] == level) begin
                cnt <= '0;
            end else if (cnt == CW'(DEBOUNCE_CYC - 1)) begin
                cnt   <= '0;
                level <= sync[1];
                press <= sync[1];
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end
endmodule

module stopwatch_bcd_counter #(
    parameter int TICK_DIV     = 1_000_000,
    parameter int DEBOUNCE_CYC = 1_000_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        btn_start_stop,
    input  logic        btn_clear,
`ifdef LAP_HOLD_EN
    input  logic        btn_lap,
`endif
    output logic [15:0] bcd_out,
    output logic        running,
    output logic        wrap
);
    localparam int PW = $clog2(TICK_DIV);
`ifdef LAP_HOLD_EN
    localparam int NUM_BTN = 3;
`else
    localparam int NUM_BTN = 2;
`endif

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE} state_t;

    logic [NUM_BTN-1:0] btn_raw;
    logic [NUM_BTN-1:0] btn_press;
    state_t             state;
    logic [PW-1:0]      presc;
    logic [3:0][3:0]    cnt;
    logic [3:0][3:0]    cnt_inc;
    logic               carry;
    logic               tick;
    logic               ss;
    logic               clr;

`ifdef LAP_HOLD_EN
    assign btn_raw = {btn_lap, btn_clear, btn_start_stop};
`else
    assign btn_raw = {btn_clear, btn_start_stop};
`endif

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
        sw_btn_path #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_btn (
            .clk   (clk),
            .rst_n (rst_n),
            .btn   (btn_raw[i]),
            .press (btn_press[i])
        );
    end

    assign ss   = btn_press[0];
    assign clr  = btn_press[1];
    assign tick = (state == S_RUN) && (presc == PW'(TICK_DIV - 1));

    // Ripple BCD increment; carry out of the top digit means 59.99 -> 00.00.
    always_comb begin
        cnt_inc = cnt;
        carry   = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (carry) begin
                if (cnt[i] == ((i == 3) ? 4'd5 : 4'd9)) begin
                    cnt_inc[i] = 4'd0;
                end else begin
                    cnt_inc[i] = cnt[i] + 4'd1;
                    carry      = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            running <= 1'b0;
            presc   <= '0;
            cnt     <= '0;
            wrap    <= 1'b0;
        end else begin
            wrap <= tick && carry;
            if (tick) cnt <= cnt_inc;
            case (state)
                S_IDLE: begin
                    if (ss) begin
                        state   <= S_RUN;
                        running <= 1'b1;
                        presc   <= '0;
                    end
                end
                S_RUN: begin
                    presc <= tick ? '0 : presc + PW'(1);
                    if (ss) begin
                        state   <= S_PAUSE;
                        running <= 1'b0;
                    end
                end
                S_PAUSE: begin
                    // Prescaler holds here so the partial tick survives a pause.
                    if (clr) begin
                        state <= S_IDLE;
                        cnt   <= '0;
                        presc <= '0;
                    end else if (ss) begin
                        state   <= S_RUN;
                        running <= 1'b1;
                    end
                end
                default: begin
                    state   <= S_IDLE;
                    running <= 1'b0;
                end
            endcase
        end
    end

`ifdef LAP_HOLD_EN
    logic        hold;
    logic [15:0] snap;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold <= 1'b0;
            snap <= '0;
        end else begin
            if (btn_press[2]) begin
                if (state == S_RUN) begin
                    hold <= !hold;
                    if (!hold) snap <= cnt;
                end else if (hold) begin
                    hold <= 1'b0;
                end
            end
            // Clearing back to IDLE always releases a frozen display.
            if (state == S_PAUSE && clr) hold <= 1'b0;
        end
    end

    assign bcd_out = hold ? snap : cnt;
`else
    assign bcd_out = cnt;
`endif
endmodule

// File: tb/tb_stopwatch_bcd_counter.sv
// Scoreboarded bench for stopwatch_bcd_counter: a centisecond-integer reference model
// predicts every cycle's outputs; a negedge monitor pops and compares them.
module tb_stopwatch_bcd_counter;
    localparam int TD = 4;
    localparam int DB = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        btn_ss = 1'b0;
    logic        btn_clr = 1'b0;
    logic        btn_lap = 1'b0;
    logic [15:0] bcd_out;
    logic        running;
    logic        wrap;

    stopwatch_bcd_counter #(.TICK_DIV(TD), .DEBOUNCE_CYC(DB)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .btn_start_stop (btn_ss),
        .btn_clear      (btn_clr),
`ifdef LAP_HOLD_EN
        .btn_lap        (btn_lap),
`endif
        .bcd_out        (bcd_out),
        .running        (running),
        .wrap           (wrap)
    );

    initial forever #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] bcd;
        logic        run;
        logic        wrp;
    } exp_t;

    typedef enum int {M_IDLE, M_RUN, M_PAUSE} mst_t;

    exp_t       sb[$];
    int         errors = 0;
    int         checks = 0;
    mst_t       m_st = M_IDLE;
    int         m_cs = 0;
    int         m_ph = 0;
    int         m_snap = 0;
    bit         m_hold = 1'b0;
    bit         m_wrap = 1'b0;
    bit [2:0]   m_deb = '0;
    bit [2:0]   m_press = '0;
    bit [15:0]  m_hist [3];

    function automatic logic [15:0] to_bcd(input int cs);
        int s;
        int c;
        s = cs / 100;
        c = cs % 100;
        return {4'(s / 10), 4'(s % 10), 4'(c / 10), 4'(c % 10)};
    endfunction

    task automatic finish_run();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    endtask

    task automatic m_reset();
        m_st = M_IDLE; m_cs = 0; m_ph = 0; m_snap = 0;
        m_hold = 1'b0; m_wrap = 1'b0; m_deb = '0; m_press = '0;
        for (int b = 0; b < 3; b++) m_hist[b] = '0;
    endtask

    // Reference model: one step per clock edge, from pre-edge model state.
    initial begin
        bit       ss, clr, lap, tick, acc;
        bit [2:0] raw;
        exp_t     e;
        m_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_reset();
                sb.delete();
                e.bcd = 16'h0000; e.run = 1'b0; e.wrp = 1'b0;
                sb.push_back(e);
            end else begin
                raw = {btn_lap, btn_clr, btn_ss};
`ifndef LAP_HOLD_EN
                raw[2] = 1'b0;
`endif
                ss = m_press[0]; clr = m_press[1]; lap = m_press[2];
                tick = (m_st == M_RUN) && (m_ph == TD - 1);
                m_wrap = tick && (m_cs == 5999);
                if (lap) begin
                    if (m_st == M_RUN) begin
                        if (!m_hold) m_snap = m_cs;
                        m_hold = !m_hold;
                    end else begin
                        m_hold = 1'b0;
                    end
                end
                case (m_st)
                    M_IDLE: if (ss) begin m_st = M_RUN; m_ph = 0; end
                    M_RUN: begin
                        if (tick) begin m_ph = 0; m_cs = (m_cs + 1) % 6000; end
                        else m_ph++;
                        if (ss) m_st = M_PAUSE;
                    end
                    M_PAUSE: begin
                        if (clr) begin m_st = M_IDLE; m_cs = 0; m_ph = 0; m_hold = 1'b0; end
                        else if (ss) m_st = M_RUN;
                    end
                    default: m_st = M_IDLE;
                endcase
                // Button: 2-sample delay, then accept once DB delayed samples all disagree.
                for (int b = 0; b < 3; b++) begin
                    m_hist[b] = {m_hist[b][14:0], raw[b]};
                    acc = m_deb[b] ? (m_hist[b][DB+1:2] == '0) : (m_hist[b][DB+1:2] == '1);
                    m_press[b] = acc && !m_deb[b];
                    if (acc) m_deb[b] = !m_deb[b];
                end
                e.bcd = to_bcd(m_hold ? m_snap : m_cs);
                e.run = (m_st == M_RUN);
                e.wrp = m_wrap;
                sb.push_back(e);
            end
        end
    end

    // Monitor
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                checks++;
                if (bcd_out !== e.bcd || running !== e.run || wrap !== e.wrp) begin
                    errors++;
                    $display("FAIL outputs t=%0t: got bcd=%h running=%b wrap=%b, expected bcd=%h running=%b wrap=%b",
                             $time, bcd_out, running, wrap, e.bcd, e.run, e.wrp);
                    if (errors >= 20) finish_run();
                end
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_btn(input int b, input logic v);
        case (b)
            0: btn_ss = v;
            1: btn_clr = v;
            default: btn_lap = v;
        endcase
    endtask

    task automatic press(input int b, input int len);
        set_btn(b, 1'b1);
        cycles(len);
        set_btn(b, 1'b0);
        cycles(12);
    endtask

    task automatic chk_now(input string name, input logic [15:0] got, input logic [15:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, got, want);
        end
    endtask

    initial begin
        cycles(3);
        rst_n = 1'b1;
        cycles(2);
        // start, ~10 ticks, pause, long idle in PAUSE
        press(0, 10);
        cycles(40);
        press(0, $urandom_range(10, 14));
        cycles(200);
        // clear from PAUSE; clear ignored in RUN; simultaneous ss+clr in PAUSE
        press(1, 10);
        press(0, 10);
        cycles(30);
        press(1, 12);
        cycles(30);
        press(0, 10);
        btn_ss = 1'b1; btn_clr = 1'b1;
        cycles(11);
        btn_ss = 1'b0; btn_clr = 1'b0;
        cycles(15);
        // full wrap 59.99 -> 00.00 and beyond
        press(0, 10);
        cycles(6000 * TD + 40);
        press(0, 10);
        // glitch shorter than debounce, then chatter followed by a held press
        btn_ss = 1'b1; cycles(2); btn_ss = 1'b0; cycles(15);
        repeat (4) begin
            btn_ss = 1'b1; cycles($urandom_range(1, 2));
            btn_ss = 1'b0; cycles($urandom_range(1, 2));
        end
        btn_ss = 1'b1; cycles(12); btn_ss = 1'b0; cycles(20);
`ifdef LAP_HOLD_EN
        press(0, 10);
        press(1, 10);
        press(0, 10);
        cycles(100);
        press(2, 10);
        cycles(20 * TD);
        press(2, 10);
        cycles(20);
        press(2, 10);
        press(0, 10);
        press(2, 10);
        press(1, 10);
`endif
        // random button activity, including sub-debounce bounces
        repeat (80) begin
            int b;
            b = $urandom_range(0, 2);
            set_btn(b, 1'b1);
            cycles($urandom_range(1, 14));
            set_btn(b, 1'b0);
            cycles($urandom_range(0, 30));
        end
        // asynchronous reset in the middle of a run
        cycles(30);
        if (m_st != M_RUN) press(0, 10);
        cycles(25);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk_now("async_reset_bcd", bcd_out, 16'h0000);
        chk_now("async_reset_running", {15'd0, running}, 16'h0000);
        chk_now("async_reset_wrap", {15'd0, wrap}, 16'h0000);
        #2 rst_n = 1'b1;
        cycles(20);
        press(0, 10);
        cycles(50);
        finish_run();
    end
endmodule
